// File: rtl/aes_round_scheduler.sv
// AES round scheduler: round-robin arbitration of two block requesters in front
// of a single iterative AES round core. It loads the granted block, steps the
// core through Nr+1 keyed cycles while presenting the round-key index, then
// holds the core result on an output handshake tagged with the requester id.
// Block words carry the first AES byte in the most significant bits.
module aes_round_scheduler (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  input  logic [1:0]   mode,
  input  logic         key_ready,
  output logic [3:0]   rk_idx,
  output logic         core_reset,
  output logic         core_enable,
  output logic [127:0] core_data,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_src,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] blk_reg;
  logic         src_reg;
  logic         rr_last;
  logic [3:0]   nr_reg;
  logic [3:0]   rnd;
  logic         grant0;
  logic         grant1;
  logic         accept;

  // Number of full AES rounds for a key-size mode; 2 and 3 both mean AES-256.
  function automatic logic [3:0] nr_of_mode(input logic [1:0] m);
    case (m)
      2'd0:    return 4'd10;
      2'd1:    return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Round-robin grant: only from IDLE with keys ready and never while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && key_ready && !reset) begin
      grant0 = req0_valid && (!req1_valid || rr_last);
      grant1 = req1_valid && (!req0_valid || !rr_last);
    end
  end

  assign accept = grant0 | grant1;

  // Next-state logic for the IDLE -> LOAD -> RUN -> DONE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (rnd == nr_reg) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset from any state drops the in-flight block.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control registers: owner id, arbitration history, round count and index.
  // The round index is cleared at accept so it never exceeds the new round count.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg <= 1'b0;
      rr_last <= 1'b1;
      nr_reg  <= 4'd10;
      rnd     <= 4'd0;
    end else if (accept) begin
      src_reg <= grant1;
      rr_last <= grant1;
      nr_reg  <= nr_of_mode(mode);
      rnd     <= 4'd0;
    end else if (state == RUN && rnd != nr_reg) begin
      rnd <= rnd + 4'd1;
    end
  end

  // Block register captures the granted plaintext at accept.
  always_ff @(posedge clk) begin
    if (reset)       blk_reg <= '0;
    else if (accept) blk_reg <= grant1 ? req1_data : req0_data;
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rk_idx      = rnd;
  assign core_reset  = reset || (state == LOAD);
  assign core_enable = (state == RUN) && !reset;
  assign core_data   = blk_reg;
  assign out_valid   = (state == DONE) && !reset;
  assign out_data    = out_valid ? core_result : '0;
  assign out_src     = src_reg;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: a behavioural AES round core and key store
// sit behind the DUT; a cycle-level transaction model predicts every output.
module tb_aes_round_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [127:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic [1:0]   mode;
  logic         key_ready;
  logic [3:0]   rk_idx;
  logic         core_reset, core_enable;
  logic [127:0] core_data, core_result;
  logic         out_valid, out_ready, out_src, busy;
  logic [127:0] out_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk_tab [0:2][0:15];

  // transaction model
  bit           t_on = 1'b0;
  int           t_acc = 0;
  int           t_nr = 10;
  logic         t_src = 1'b0;
  logic [127:0] t_pt, t_exp;
  logic         m_last = 1'b1;

  // observations
  logic         acc0 = 1'b0, acc1 = 1'b0;
  int           obs_acc = 0, obs_lat = 0, n_done = 0;
  logic [127:0] obs_data = '0;
  logic         obs_src = 1'b0, obs_prev_vld = 1'b0;
  int           rk_q[$];
  int           gq[$];

  // behavioural core
  logic [127:0] core_st;
  int           c_kind = 0;
  int           c_nr = 10;

  aes_round_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .mode(mode), .key_ready(key_ready), .rk_idx(rk_idx),
    .core_reset(core_reset), .core_enable(core_enable), .core_data(core_data),
    .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  function automatic int kind_of(input logic [1:0] m);
    return (m == 2'd0) ? 0 : (m == 2'd1) ? 1 : 2;
  endfunction

  // one AES step: key 0 = AddRoundKey only, key nr = final round (no MixColumns)
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                             input int idx, input int nr);
    logic [7:0]   a [0:15];
    logic [7:0]   b [0:15];
    logic [127:0] o;
    if (idx == 0) return st ^ k;
    for (int i = 0; i < 16; i++) a[i] = sbox_tab[st[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (idx != nr) begin
      for (int c = 0; c < 4; c++) begin
        a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
        b[4*c]   = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        b[4*c+1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        b[4*c+2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        b[4*c+3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input int kind);
    logic [127:0] s = pt;
    int nr = 10 + 2 * kind;
    for (int r = 0; r <= nr; r++) s = aes_round(s, rk_tab[kind][r], r, nr);
    return s;
  endfunction

  // S-box from GF(2^8) inverse plus affine map; key schedules for key 00 01 02 ...
  task automatic build_tables();
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc, inv;
    int nk, nr;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int kind = 0; kind < 3; kind++) begin
      nk = 4 + 2 * kind;
      nr = 10 + 2 * kind;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      for (int i = nk; i < 4 * (nr + 1); i++) begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk_tab[kind][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // behavioural iterative round core with its own copy of the accepted key size
  always @(posedge clk) begin
    if (!reset && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
      c_kind <= kind_of(mode);
      c_nr   <= 10 + 2 * kind_of(mode);
    end
    if (core_reset)       core_st <= core_data;
    else if (core_enable) core_st <= aes_round(core_st, rk_tab[c_kind][rk_idx], int'(rk_idx), c_nr);
  end
  assign core_result = core_st;

  // one clock: check all outputs against the model, then advance the model
  task automatic step();
    bit ld, en, vld, g0, g1;
    #1;
    ld  = t_on && cyc == t_acc + 1;
    en  = t_on && !reset && cyc >= t_acc + 2 && cyc <= t_acc + 2 + t_nr;
    vld = t_on && !reset && cyc >= t_acc + 3 + t_nr;
    g0  = !t_on && key_ready && !reset && req0_valid && (!req1_valid || m_last);
    g1  = !t_on && key_ready && !reset && req1_valid && (!req0_valid || !m_last);
    check("busy", 128'(busy), 128'(t_on));
    check("req0_ready", 128'(req0_ready), 128'(g0));
    check("req1_ready", 128'(req1_ready), 128'(g1));
    check("out_valid", 128'(out_valid), 128'(vld));
    check("core_enable", 128'(core_enable), 128'(en));
    check("core_reset", 128'(core_reset), 128'(reset || ld));
    if (ld)  check("core_data", core_data, t_pt);
    if (en)  check("rk_idx", 128'(rk_idx), 128'(cyc - t_acc - 2));
    if (vld) begin
      check("out_data", out_data, t_exp);
      check("out_src", 128'(out_src), 128'(t_src));
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0 || acc1) obs_acc = cyc;
    if (core_enable) rk_q.push_back(int'(rk_idx));
    if (out_valid && !obs_prev_vld) obs_lat = cyc - obs_acc;
    if (out_valid && out_ready) begin
      obs_data = out_data;
      obs_src  = out_src;
      n_done++;
    end
    obs_prev_vld = out_valid;
    if (reset) begin
      t_on = 1'b0;
      m_last = 1'b1;
    end else if (vld && out_ready) begin
      t_on = 1'b0;
    end else if (g0 || g1) begin
      t_on   = 1'b1;
      t_acc  = cyc;
      t_src  = g1;
      m_last = g1;
      t_pt   = g1 ? req1_data : req0_data;
      t_nr   = 10 + 2 * kind_of(mode);
      t_exp  = aes_encrypt(t_pt, kind_of(mode));
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    reset      = 1'b0;
    while (busy && g < 40) begin
      step();
      g++;
    end
    check("drain_idle", 128'(busy), 128'(0));
  endtask

  // single block from requester 0 against a known-answer ciphertext and latency
  task automatic run_one(input logic [127:0] pt, input logic [1:0] md,
                         input logic [127:0] kat, input int lat, input string tg);
    int base = n_done;
    int g = 0;
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_data  = pt;
    mode       = md;
    key_ready  = 1'b1;
    out_ready  = 1'b1;
    while (n_done == base && g < 60) begin
      step();
      if (acc0) req0_valid = 1'b0;
      g++;
    end
    check({tg, "_done"}, 128'(n_done - base), 128'(1));
    check({tg, "_data"}, obs_data, kat);
    check({tg, "_src"}, 128'(obs_src), 128'(0));
    check({tg, "_lat"}, 128'(obs_lat), 128'(lat));
  endtask

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int g;
    build_tables();
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = PT;
    req1_valid = 1'b1; req1_data = ~PT;
    mode = 2'd0; key_ready = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_req0_ready", 128'(req0_ready), 128'(0));
    check("rst_req1_ready", 128'(req1_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_core_reset", 128'(core_reset), 128'(1));
    check("rst_core_enable", 128'(core_enable), 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    check("rst_out_src", 128'(out_src), 128'(0));
    check("rst_core_data", core_data, 128'(0));
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // known answers for the three key sizes, with the round-key index sequence
    rk_q.delete();
    run_one(PT, 2'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 13, "kat128");
    check("rk_count", 128'(rk_q.size()), 128'(11));
    for (int i = 0; i < rk_q.size(); i++) check("rk_seq", 128'(rk_q[i]), 128'(i));
    run_one(PT, 2'd1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 15, "kat192");
    run_one(PT, 2'd3, 128'h8ea2b7ca516745bfeafc49904b496089, 17, "kat256");

    // both requesters permanently valid: grants alternate starting with 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    gq.delete();
    req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    req1_valid = 1'b1; req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    mode = 2'd0; key_ready = 1'b1; out_ready = 1'b1;
    g = n_done;
    for (int i = 0; i < 200 && n_done < g + 4; i++) begin
      step();
      if (acc0) begin gq.push_back(0); req0_data = {$urandom(), $urandom(), $urandom(), $urandom()}; end
      if (acc1) begin gq.push_back(1); req1_data = {$urandom(), $urandom(), $urandom(), $urandom()}; end
    end
    drain();
    check("rr_grants", 128'(gq.size() >= 4), 128'(1));
    for (int i = 0; i < 4 && i < gq.size(); i++) check("rr_order", 128'(gq[i]), 128'(i % 2));

    // back-pressure in DONE with a second requester waiting
    req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    mode = 2'd1; key_ready = 1'b1; out_ready = 1'b0;
    g = 0;
    while (!out_valid && g < 40) begin
      step();
      if (acc0) begin
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      g++;
    end
    repeat (5) step();
    check("bp_valid_held", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    step();
    step();
    check("bp_accept_next", 128'(acc1), 128'(1));
    req1_valid = 1'b0;
    drain();

    // key_ready gates the grant; raising it accepts in the same cycle
    key_ready = 1'b0;
    req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    mode = 2'd2;
    repeat (3) step();
    check("kr_not_busy", 128'(busy), 128'(0));
    key_ready = 1'b1;
    step();
    check("kr_accept", 128'(acc0), 128'(1));
    drain();

    // reset in the middle of RUN discards the block; the next one completes
    req0_valid = 1'b1; req0_data = PT; mode = 2'd0; key_ready = 1'b1; out_ready = 1'b1;
    g = 0;
    while (!acc0 && g < 10) begin step(); g++; end
    req0_valid = 1'b0;
    g = 0;
    while (!(core_enable && rk_idx == 4'd5) && g < 20) begin step(); g++; end
    check("mid_rk5", 128'(rk_idx), 128'(5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_idle", 128'(busy), 128'(0));
    check("mid_out_valid", 128'(out_valid), 128'(0));
    run_one(PT, 2'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 13, "after_rst");

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      mode      = 2'($urandom_range(0, 3));
      key_ready = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 149) == 0);
      step();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
